// File: rtl/ped_pkg.sv
// ped_pkg: shared types and defaults for the pedestrian button conditioner.
//   ped_state_t          : debounce FSM state, 2-bit
//   PED_DEBOUNCE_DEFAULT : stable samples needed to accept a press/release
//   PED_REPEAT_DEFAULT   : cycles between auto-repeat pulses while held
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } ped_state_t;

  localparam int PED_DEBOUNCE_DEFAULT = 16;
  localparam int PED_REPEAT_DEFAULT   = 64;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both stages cleared to 0
//   i_d  - asynchronous input level
//   o_q  - synchronized level (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ped_request.sv
// ped_request: turns a raw bouncing push-button into a clean single-cycle
// request pulse for the step sequencer, plus a debounced level.
// Both edges are debounced: a level change is accepted only after
// DEBOUNCE_CYCLES+1 consecutive synchronized samples of the new level
// (the entry sample plus DEBOUNCE_CYCLES in the wait state).
// Optional feature macro: PED_AUTOREPEAT_EN -- while held, re-issue ped
// every REPEAT_CYCLES cycles.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   btn_raw - raw button level, asynchronous, 1 = pressed
//   ped     - registered request pulse, one cycle per event
//   held    - registered debounced button level
module ped_request
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_DEFAULT,
  parameter int REPEAT_CYCLES   = PED_REPEAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic ped,
  output logic held
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            w_btn_s;
  ped_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ped;
  logic            r_held;

`ifdef PED_AUTOREPEAT_EN
  localparam int             RW       = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]   r_rep;
`else
  // Repeat interval has no meaning in this build.
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYCLES > 1);
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_raw),
    .o_q (w_btn_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ped   <= 1'b0;
      r_held  <= 1'b0;
`ifdef PED_AUTOREPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_ped <= 1'b0;
`ifdef PED_AUTOREPEAT_EN
      // Zero outside steady HELD, so every HELD entry restarts the interval.
      r_rep <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_ped   <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_btn_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
`ifdef PED_AUTOREPEAT_EN
          else if (r_rep == REP_LAST) begin
            r_ped <= 1'b1;
          end else begin
            r_rep <= r_rep + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (w_btn_s) begin
            // Release glitch: back to HELD without a new pulse.
            r_state <= HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ped  = r_ped;
  assign held = r_held;

endmodule

// File: tb/tb_ped_request.sv
// tb_ped_request: randomized + directed bench for ped_request.
// The reference model tracks the debounced level as a run length of
// synchronized samples: a level flips once D+1 consecutive samples of the
// opposite value are seen; a flip to 1 is a press pulse. Expected pulse
// cycles are queued and a negedge monitor pops them as the DUT pulses.
// Build with +define+PED_AUTOREPEAT_EN to cover the repeat feature.
module tb_ped_request;

  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic ped;
  logic held;

  always #5 clk = ~clk;

  ped_request #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .ped     (ped),
    .held    (held)
  );

  int n_chk   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];
  bit exp_held = 1'b0;
  int m_pulses = 0;
  bit h0 = 1'b0, h1 = 1'b0;
  bit lvl = 1'b0;
  int run = 0;
  int rep = 0;
  bit prev_ped = 1'b0;
  logic [2:0] seq;

  // Reference model: raw level reaches the FSM two edges after sampling.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; exp_q.delete(); lvl = 0; run = 0; rep = 0;
      h0 = 0; h1 = 0; exp_held = 0;
    end else begin
      bit s;
      bit stable;
      s      = h1;
      stable = (run == 0);
      cyc++;
      if (s != lvl) begin
        run++;
        rep = 0;
        if (run == D + 1) begin
          lvl = s;
          run = 0;
          if (s) begin
            exp_q.push_back(cyc);
            m_pulses++;
          end
        end
      end else begin
        run = 0;
`ifdef PED_AUTOREPEAT_EN
        if (lvl && stable) begin
          rep++;
          if (rep == R) begin
            rep = 0;
            exp_q.push_back(cyc);
            m_pulses++;
          end
        end else begin
          rep = 0;
        end
`endif
      end
      exp_held = lvl;
      h1 = h0;
      h0 = btn_raw;
    end
  end

  // Sequencer stand-in: 3-bit step counter advanced by ped.
  always @(posedge clk or posedge rst) begin
    if (rst) seq <= 3'd0;
    else if (ped) seq <= seq + 3'd1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      int e;
      n_chk++;
      if (held !== exp_held) begin
        n_fail++;
        $display("FAIL held @cyc %0d: got %b expected %b", cyc, held, exp_held);
      end
      if (ped === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ped_unexpected @cyc %0d: got 1 expected 0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL ped_cycle: got %0d expected %0d", cyc, e);
          end
        end
        if (prev_ped) begin
          n_fail++;
          $display("FAIL ped_consecutive @cyc %0d: got 1 twice expected single", cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        n_chk++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL ped_missing: got %b at cyc %0d expected 1 at %0d", ped, cyc, e);
      end
      prev_ped = (ped === 1'b1);
    end else begin
      prev_ped = 1'b0;
    end
  end

  task automatic drive(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  initial begin
    int p0;
    logic [2:0] s0;
    repeat (3) @(negedge clk);
    check("reset_ped", int'(ped), 0);
    check("reset_held", int'(held), 0);
    rst = 1'b0;

    // Clean press.
    p0 = m_pulses;
    drive(1, 20); drive(0, 20);
    check("clean_pulses", m_pulses - p0, 1);

    // Press bounce.
    p0 = m_pulses;
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    drive(1, 20); drive(0, 20);

    // Release bounce.
    drive(1, 20); drive(0, 2); drive(1, 1); drive(0, 20);
`ifndef PED_AUTOREPEAT_EN
    check("bounce_pulses", m_pulses - p0, 2);
`endif

    // Asynchronous reset while HELD, button stays pressed.
    drive(1, 20);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ped", int'(ped), 0);
    check("async_rst_held", int'(held), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p0 = m_pulses;
    drive(1, 8); drive(0, 20);
    check("post_reset_pulses", m_pulses - p0, 1);

    // Long hold: repeat pulses only with the feature built in.
    p0 = m_pulses;
    drive(1, 40); drive(0, 20);
`ifdef PED_AUTOREPEAT_EN
    check("hold_pulses", m_pulses - p0, 5);
`else
    check("hold_pulses", m_pulses - p0, 1);
`endif

    // Sequencer pairing: nine clean presses, one step each.
    s0 = seq;
    p0 = m_pulses;
    repeat (9) begin
      drive(1, 8); drive(0, 12);
    end
    check("press_count", m_pulses - p0, 9);
    check("seq_step", int'(seq), int'(3'(s0 + 3'd1)));

    // Random bouncing.
    repeat (200) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    drive(0, 30);
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_request.md
# ped_request

Conditions a raw, asynchronous, bouncing pedestrian push-button into the clean `ped` request consumed by the 3-bit step sequencer. The block synchronizes the button and debounces both edges with a cycle counter. It emits exactly one single-cycle `ped` pulse per accepted press, or periodic pulses while held when auto-repeat is compiled in. It sits between the board button pin and the sequencer's `ped` input, in the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a press or a release; legal range is ≥1.
- `REPEAT_CYCLES`, default 64: cycles between auto-repeat pulses while held; used only with `PED_AUTOREPEAT_EN`; legal range is ≥2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high; clock `clk`.
- `btn_raw` input 1: raw button level, asynchronous to `clk`; 1 means pressed.
- `ped` output 1: registered request pulse, high for exactly one cycle per event.
- `held` output 1: registered debounced button level.

## Operation
- **Synchronizer:** 2-FF synchronizer feeds `btn_s`. Both stages reset to 0.
- **Debounce counter `cnt`:** width `$clog2(DEBOUNCE_CYCLES)+1`. It never wraps, because leaving the wait state clears it.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - **IDLE** (`held`=0): if `btn_s`=1, go to PRESS_WAIT with `cnt`=0.
  - **PRESS_WAIT** (`held`=0):
    - if `btn_s`=0, go to IDLE; the bounce is rejected and no pulse is emitted.
    - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to HELD and set `ped`<=1.
    - else `cnt`++.
  - **HELD** (`held`=1): if `btn_s`=0, go to RELEASE_WAIT with `cnt`=0.
  - **RELEASE_WAIT** (`held`=1):
    - if `btn_s`=1, return to HELD with no new pulse; a release glitch is ignored.
    - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE with `held`<=0.
    - else `cnt`++.
- **`ped` behaviour:** `ped` is the default-0 registered strobe. It is never high in two consecutive cycles.
- **`held`:** registered, equal to 1 in HELD and RELEASE_WAIT.
- **Reset:** `rst`=1 forces the following immediately, regardless of `clk`:
  - state IDLE;
  - `cnt`=0;
  - repeat counter 0;
  - both synchronizer stages 0;
  - `ped`=0, `held`=0.
- **Reset mid-press:** a reset applied while the button is pressed re-debounces from IDLE after release of `rst`. One fresh pulse follows if the button stays pressed.

## Timing
- Edge numbering: edge 0 is the first rising edge that samples `btn_raw`=1 into stage 1, with `btn_raw` stable thereafter.
- **Press latency:** `ped`=1 and `held`=1 after edge `DEBOUNCE_CYCLES`+2. `ped` returns to 0 after the next edge. With the default, the pulse is between edges 18 and 19.
- **Release latency:** `held`=0 after edge `DEBOUNCE_CYCLES`+2, counted from the first edge sampling `btn_raw`=0.
- **Bounce rejection:** any 0 sample in PRESS_WAIT, or 1 sample in RELEASE_WAIT, restarts debounce from the opposite stable state.
- **`DEBOUNCE_CYCLES`=1:** PRESS_WAIT and RELEASE_WAIT each last exactly one cycle.

## Configuration
- **`PED_AUTOREPEAT_EN` defined:**
  - A repeat counter of width `$clog2(REPEAT_CYCLES)` is cleared on every entry to HELD.
  - It counts while in HELD.
  - At `REPEAT_CYCLES`-1 it sets `ped`<=1 and clears.
  - It is held at 0 in all other states, so a RELEASE_WAIT→HELD bounce restarts the repeat interval.
  - First repeat pulse: `REPEAT_CYCLES` cycles after the press pulse.
- **Undefined:** no repeat counter exists, and exactly one pulse is emitted per accepted press.

## Structure
- **Shared package `ped_pkg`:**
  - 2-bit state typedef `ped_state_t` with encodings IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3;
  - default constants `PED_DEBOUNCE_DEFAULT`=16 and `PED_REPEAT_DEFAULT`=64.
- **Sub-module `sync_2ff`:** 1-bit, async reset to 0. It is reused by other button inputs in the design.
- **Top `ped_request`:** FSM, debounce counter, optional repeat counter and output registers.

## Test plan
- **Clean press:** `DEBOUNCE_CYCLES`=4, `btn_raw`=1 held 20 cycles, then 0 → `ped` high for exactly 1 cycle after edge 6. `held` is 1 from edge 6 and falls 6 edges after release.
- **Press bounce:** `btn_raw` toggles 1,0,1,0 one cycle each, then stays 1 → no pulse during the toggling. Exactly one `ped` occurs 6 edges after the final stable 1 is sampled.
- **Release bounce:** while HELD, `btn_raw` 0 for 2 cycles, 1 for 1 cycle, then 0 stable → no extra `ped`. `held` remains 1 until 6 edges after the last 1 is sampled.
- **Reset mid-operation:** assert `rst` asynchronously in HELD → `ped`=0, `held`=0 immediately. After deassert with the button still pressed, one new pulse occurs at edge 6.
- **Auto-repeat:** with `PED_AUTOREPEAT_EN`, `REPEAT_CYCLES`=8, `DEBOUNCE_CYCLES`=4, button held 40 cycles → pulses at cycle offsets 0, 8, 16, 24, 32 from the first pulse. Without the macro: one pulse.
- **Sequencer pairing:** drive the sequencer with `ped`; 9 clean presses → sequencer state advances 0→1→…→7→0→1, one step per press.
